// File: rtl/spi_temp_reader.sv
// spi_temp_reader
// SPI master for read-only LM07-class temperature sensors. One shared SCK,
// NCH active-low chip selects, FRAME_BITS-bit frames shifted in MSB first,
// leading DATA_BITS kept and offered on a valid/ready result port with the
// channel number. Single-shot (start) or round-robin (auto_en) operation.
// Build macro TS_CLAMP_EN: when defined, the loaded result is clamped to
// 0..99 (negative readings become 0) so bin2BCD always sees two digits.
module spi_temp_reader #(
    parameter int NCH         = 2,
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SCK_DIV     = 2,
    parameter int CS_SETUP    = 2,
    parameter int IDLE_CYCLES = 4
) (
    input  logic                                     SYSCLK,
    input  logic                                     RSTN,
    input  logic                                     start,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] start_ch,
    input  logic                                     auto_en,
    input  logic                                     SIO,
    output logic [NCH-1:0]                           CS,
    output logic                                     SCK,
    output logic                                     busy,
    output logic [DATA_BITS-1:0]                     rd_data,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_ch,
    output logic                                     rd_valid,
    input  logic                                     rd_ready,
    output logic                                     overrun
);

    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_MAX = (SCK_DIV > CS_SETUP)
                             ? ((SCK_DIV > IDLE_CYCLES) ? SCK_DIV : IDLE_CYCLES)
                             : ((CS_SETUP > IDLE_CYCLES) ? CS_SETUP : IDLE_CYCLES);
    localparam int CNTW    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int HALF_W  = $clog2(2 * FRAME_BITS);
    localparam logic [NCH-1:0] NCH_ONE = NCH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [CNTW-1:0]      cnt_reg, cnt_next;
    logic [HALF_W-1:0]    half_reg, half_next;
    logic                 done_reg, done_next;
    logic [CHW-1:0]       ch_reg, ch_next;
    logic [CHW-1:0]       ptr_reg, ptr_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [NCH-1:0]       cs_reg, cs_next;
    logic                 sck_reg, sck_next;
    logic                 busy_reg, busy_next;
    logic [DATA_BITS-1:0] rd_data_reg, rd_data_next;
    logic [CHW-1:0]       rd_ch_reg, rd_ch_next;
    logic                 rd_valid_reg, rd_valid_next;
    logic                 overrun_reg, overrun_next;

    logic                 launch;
    logic                 load;
    logic                 consume;
    logic [CHW-1:0]       start_mod;
    logic [CHW-1:0]       launch_ch;
    logic [CHW-1:0]       ch_inc;
    logic [DATA_BITS-1:0] result;

    assign launch  = (state_reg == S_IDLE) && (start || auto_en);
    // done_reg marks the cycle after CS has risen; the result is taken then.
    assign load    = (state_reg == S_SHIFT) && done_reg;
    assign consume = rd_valid_reg && rd_ready;

    // Fold out-of-range channel requests back into 0..NCH-1.
    always_comb begin
        if (int'(start_ch) >= NCH) start_mod = CHW'(int'(start_ch) - NCH);
        else                       start_mod = start_ch;
    end

    // Explicit start takes priority over the round-robin pointer.
    always_comb begin
        launch_ch = start ? start_mod : ptr_reg;
    end

    // Next channel in round-robin order.
    always_comb begin
        if (int'(ch_reg) >= NCH - 1) ch_inc = '0;
        else                         ch_inc = ch_reg + 1'b1;
    end

`ifdef TS_CLAMP_EN
    // Clamp to the two-digit display range: negative -> 0, above 99 -> 99.
    always_comb begin
        if (shift_reg[DATA_BITS-1])           result = '0;
        else if (shift_reg > DATA_BITS'(99))  result = DATA_BITS'(99);
        else                                  result = shift_reg;
    end
`else
    assign result = shift_reg;
`endif

    // FSM state register.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (launch) state_next = S_SETUP;
            S_SETUP: if (int'(cnt_reg) == CS_SETUP - 1) state_next = S_SHIFT;
            S_SHIFT: if (done_reg) state_next = S_GAP;
            S_GAP:   if (int'(cnt_reg) == IDLE_CYCLES - 1) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output / datapath next values: pin timing, shifting and the result handshake.
    always_comb begin
        cnt_next      = cnt_reg;
        half_next     = half_reg;
        done_next     = done_reg;
        ch_next       = ch_reg;
        ptr_next      = ptr_reg;
        shift_next    = shift_reg;
        cs_next       = cs_reg;
        sck_next      = sck_reg;
        rd_data_next  = rd_data_reg;
        rd_ch_next    = rd_ch_reg;
        rd_valid_next = rd_valid_reg;
        overrun_next  = overrun_reg;
        busy_next     = (state_next != S_IDLE);

        unique case (state_reg)
            S_IDLE: begin
                if (launch) begin
                    ch_next    = launch_ch;
                    cs_next    = ~(NCH_ONE << launch_ch);
                    cnt_next   = '0;
                    shift_next = '0;
                end
            end
            S_SETUP: begin
                if (int'(cnt_reg) == CS_SETUP - 1) begin
                    cnt_next  = '0;
                    half_next = '0;
                    sck_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_SHIFT: begin
                if (done_reg) begin
                    done_next = 1'b0;
                    cnt_next  = '0;
                    ptr_next  = ch_inc;
                end else if (int'(cnt_reg) == SCK_DIV - 1) begin
                    cnt_next = '0;
                    if (int'(half_reg) == 2 * FRAME_BITS - 1) begin
                        // End of the last low phase: release the sensor.
                        cs_next   = '1;
                        done_next = 1'b1;
                    end else begin
                        half_next = half_reg + 1'b1;
                        sck_next  = ~sck_reg;
                        // Falling edge at the end of a high phase: sample SIO.
                        // Even half h carries bit h/2; keep the first DATA_BITS.
                        if (sck_reg && (int'(half_reg) < 2 * DATA_BITS))
                            shift_next = (shift_reg << 1) | DATA_BITS'(SIO);
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_GAP: begin
                cnt_next = cnt_reg + 1'b1;
            end
            default: ;
        endcase

        if (load) begin
            rd_data_next  = result;
            rd_ch_next    = ch_reg;
            rd_valid_next = 1'b1;
            // Overwriting an unread result is sticky; a simultaneous read is fine.
            if (rd_valid_reg && !rd_ready) overrun_next = 1'b1;
        end else if (consume) begin
            rd_valid_next = 1'b0;
            overrun_next  = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_reg      <= '0;
            half_reg     <= '0;
            done_reg     <= 1'b0;
            ch_reg       <= '0;
            ptr_reg      <= '0;
            shift_reg    <= '0;
            cs_reg       <= '1;
            sck_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            rd_data_reg  <= '0;
            rd_ch_reg    <= '0;
            rd_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            half_reg     <= half_next;
            done_reg     <= done_next;
            ch_reg       <= ch_next;
            ptr_reg      <= ptr_next;
            shift_reg    <= shift_next;
            cs_reg       <= cs_next;
            sck_reg      <= sck_next;
            busy_reg     <= busy_next;
            rd_data_reg  <= rd_data_next;
            rd_ch_reg    <= rd_ch_next;
            rd_valid_reg <= rd_valid_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign CS       = cs_reg;
    assign SCK      = sck_reg;
    assign busy     = busy_reg;
    assign rd_data  = rd_data_reg;
    assign rd_ch    = rd_ch_reg;
    assign rd_valid = rd_valid_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_spi_temp_reader.sv
// tb_spi_temp_reader: self-checking bench for spi_temp_reader at default
// parameters, with a behavioural sensor model on SIO.
module tb_spi_temp_reader;

    logic       SYSCLK;
    logic       RSTN;
    logic       start;
    logic [0:0] start_ch;
    logic       auto_en;
    logic       SIO;
    logic [1:0] CS;
    logic       SCK;
    logic       busy;
    logic [7:0] rd_data;
    logic [0:0] rd_ch;
    logic       rd_valid;
    logic       rd_ready;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    spi_temp_reader #(
        .NCH(2), .FRAME_BITS(16), .DATA_BITS(8),
        .SCK_DIV(2), .CS_SETUP(2), .IDLE_CYCLES(4)
    ) dut (
        .SYSCLK(SYSCLK), .RSTN(RSTN), .start(start), .start_ch(start_ch),
        .auto_en(auto_en), .SIO(SIO), .CS(CS), .SCK(SCK), .busy(busy),
        .rd_data(rd_data), .rd_ch(rd_ch), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .overrun(overrun)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    // Sensor model: MSB presented when selected, next bit after each SCK fall.
    logic [15:0] sensor_word [2];
    int          bit_idx = 15;
    logic        sens_prev_sck = 1'b0;

    always @(posedge SYSCLK) begin
        #1;
        if (CS == 2'b11)                bit_idx = 15;
        else if (sens_prev_sck && !SCK) bit_idx = bit_idx - 1;
        sens_prev_sck = SCK;
    end

    always @* begin
        SIO = 1'b0;
        for (int c = 0; c < 2; c++)
            if (!CS[c] && bit_idx >= 0 && bit_idx < 16) SIO = sensor_word[c][bit_idx];
    end

    // Reference: leading 8 bits of the frame, optionally clamped to 0..99.
    function automatic logic [7:0] model(input logic [15:0] w);
        logic [7:0] raw;
        raw = w[15:8];
`ifdef TS_CLAMP_EN
        if (raw >= 8'd128) return 8'd0;
        if (raw > 8'd99) return 8'd99;
`endif
        return raw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(posedge SYSCLK); #1; k++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic pulse_ready();
        @(negedge SYSCLK); rd_ready = 1'b1;
        @(posedge SYSCLK); #1; rd_ready = 1'b0;
    endtask

    // One single-shot frame with timing measurements from the start edge.
    task automatic run_single(input int ch, input logic [15:0] word,
                              input logic [7:0] exp_data, input bit consume_after);
        int k, cs_low, other_low, pulses, end_k;
        logic prev_sck, prior_valid, valid_at_end;
        sensor_word[ch] = word;
        prior_valid = rd_valid;
        valid_at_end = 1'bx;
        @(negedge SYSCLK); start = 1'b1; start_ch = 1'(ch);
        @(posedge SYSCLK); #1; start = 1'b0;
        k = 0; cs_low = 0; other_low = 0; pulses = 0; prev_sck = 1'b0; end_k = -1;
        while (k < 200) begin
            if (!CS[ch]) cs_low++;
            if (!CS[1-ch]) other_low++;
            if (SCK && !prev_sck) pulses++;
            prev_sck = SCK;
            if (end_k < 0 && cs_low > 0 && CS == 2'b11) begin
                end_k = k;
                valid_at_end = rd_valid;
            end
            if (end_k >= 0 && k == end_k + 1) break;
            @(posedge SYSCLK); #1; k++;
        end
        check("latency", k, 67);
        check("cs_low_cycles", cs_low, 66);
        check("sck_pulses", pulses, 16);
        check("other_cs_low", other_low, 0);
        check("valid_before_load", valid_at_end, prior_valid);
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, exp_data);
        check("rd_ch", rd_ch, ch);
        $display("frame ch=%0d word=%h rd_data=%h rd_ch=%0d latency=%0d", ch, word, rd_data, rd_ch, k);
        if (consume_after) begin
            pulse_ready();
            check("consume_clears_valid", rd_valid, 0);
            check("consume_overrun", overrun, 0);
        end
        wait_idle("single");
    endtask

    task automatic wait_load(input string tag);
        int k;
        bit seen_low, found;
        k = 0; seen_low = 0; found = 0;
        while (k < 300) begin
            @(posedge SYSCLK); #1; k++;
            if (CS != 2'b11) seen_low = 1;
            else if (seen_low) begin
                found = 1;
                break;
            end
        end
        check({tag, "_frame_end_seen"}, found, 1);
        @(posedge SYSCLK); #1;
    endtask

    typedef struct {
        int          ch;
        logic [15:0] word;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        int         ch;
        logic [7:0] d;
    } exp_t;

    vec_t vecs [8];
    exp_t exp_q [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, pulses, launches, loads, last_launch, cur, cnt;
        logic prev_sck;
        logic [1:0] prev_cs;
        logic [15:0] w;
        exp_t e;

`ifdef TS_CLAMP_EN
        vecs[0] = '{1, 16'h1900, 8'h19};
        vecs[1] = '{0, 16'h7F00, 8'd99};
        vecs[2] = '{1, 16'h8A00, 8'd0};
        vecs[3] = '{0, 16'hFFFF, 8'd0};
        vecs[4] = '{1, 16'h00FF, 8'h00};
        vecs[5] = '{0, 16'h5555, 8'h55};
        vecs[6] = '{1, 16'h6300, 8'd99};
        vecs[7] = '{0, 16'h6400, 8'd99};
`else
        vecs[0] = '{1, 16'h1900, 8'h19};
        vecs[1] = '{0, 16'h7F00, 8'h7F};
        vecs[2] = '{1, 16'h8A00, 8'h8A};
        vecs[3] = '{0, 16'hFFFF, 8'hFF};
        vecs[4] = '{1, 16'h00FF, 8'h00};
        vecs[5] = '{0, 16'h5555, 8'h55};
        vecs[6] = '{1, 16'h6300, 8'h63};
        vecs[7] = '{0, 16'h6400, 8'h64};
`endif

        RSTN = 1'b0; start = 1'b0; start_ch = 1'b0; auto_en = 1'b0; rd_ready = 1'b0;
        sensor_word[0] = 16'h0000; sensor_word[1] = 16'h0000;
        repeat (3) @(posedge SYSCLK);
        @(negedge SYSCLK); RSTN = 1'b1;
        @(posedge SYSCLK); #1;
        check("reset_cs", CS, 2'b11);
        check("reset_sck", SCK, 0);
        check("reset_busy", busy, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_ch", rd_ch, 0);
        check("reset_overrun", overrun, 0);

        // Table of single-shot frames.
        for (int i = 0; i < 8; i++)
            run_single(vecs[i].ch, vecs[i].word, vecs[i].exp, 1);

        // Reset during SHIFT with an unread result pending.
        run_single(0, 16'h1234, model(16'h1234), 0);
        sensor_word[1] = 16'hABCD;
        @(negedge SYSCLK); start = 1'b1; start_ch = 1'b1;
        @(posedge SYSCLK); #1; start = 1'b0;
        pulses = 0; prev_sck = 1'b0; k = 0;
        while (pulses < 5 && k < 200) begin
            @(posedge SYSCLK); #1; k++;
            if (SCK && !prev_sck) pulses++;
            prev_sck = SCK;
        end
        check("reset_test_reached_period5", pulses, 5);
        @(posedge SYSCLK); #2; RSTN = 1'b0;
        @(posedge SYSCLK); #1;
        check("midreset_cs", CS, 2'b11);
        check("midreset_sck", SCK, 0);
        check("midreset_busy", busy, 0);
        check("midreset_rd_valid", rd_valid, 0);
        check("midreset_rd_data", rd_data, 0);
        $display("reset mid-frame cs=%b sck=%b busy=%b rd_valid=%b", CS, SCK, busy, rd_valid);
        @(negedge SYSCLK); RSTN = 1'b1;
        run_single(1, 16'h1900, model(16'h1900), 1);

        // Auto round-robin with the consumer always ready.
        sensor_word[0] = 16'($urandom); sensor_word[1] = 16'($urandom);
        @(negedge SYSCLK); rd_ready = 1'b1; auto_en = 1'b1;
        launches = 0; loads = 0; last_launch = 0; prev_cs = 2'b11; k = 0;
        exp_q.delete();
        while (loads < 4 && k < 600) begin
            @(posedge SYSCLK); #1; k++;
            if (prev_cs == 2'b11 && CS != 2'b11) begin
                cur = CS[0] ? 1 : 0;
                check("auto_ch_order", cur, launches % 2);
                if (launches > 0) check("auto_period", k - last_launch, 72);
                last_launch = k;
                launches++;
                exp_q.push_back('{cur, model(sensor_word[cur])});
                if (launches == 4) auto_en = 1'b0;
            end
            prev_cs = CS;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL auto_extra_load: got rd_valid=1 ch=%0d, expected no load", rd_ch);
                end else begin
                    e = exp_q.pop_front();
                    check("auto_rd_data", rd_data, e.d);
                    check("auto_rd_ch", rd_ch, e.ch);
                end
                $display("auto load ch=%0d rd_data=%h overrun=%b", rd_ch, rd_data, overrun);
                loads++;
                sensor_word[0] = 16'($urandom); sensor_word[1] = 16'($urandom);
            end
        end
        check("auto_loads", loads, 4);
        check("auto_overrun", overrun, 0);
        cnt = 0;
        repeat (100) begin
            @(posedge SYSCLK); #1;
            if (CS != 2'b11) cnt++;
        end
        check("auto_stops_after_disable", cnt, 0);
        check("auto_idle_busy", busy, 0);
        @(negedge SYSCLK); rd_ready = 1'b0;

        // Two auto frames with no consumer: overrun.
        sensor_word[0] = 16'($urandom); sensor_word[1] = 16'($urandom);
        @(negedge SYSCLK); auto_en = 1'b1;
        wait_load("ovr1");
        check("ovr_first_valid", rd_valid, 1);
        check("ovr_first_overrun", overrun, 0);
        check("ovr_first_ch", rd_ch, 0);
        wait_load("ovr2");
        auto_en = 1'b0;
        check("ovr_second_overrun", overrun, 1);
        check("ovr_second_data", rd_data, model(sensor_word[1]));
        check("ovr_second_ch", rd_ch, 1);
        $display("overrun load ch=%0d rd_data=%h overrun=%b", rd_ch, rd_data, overrun);
        repeat (20) @(posedge SYSCLK); #1;
        check("ovr_idle_busy", busy, 0);
        check("ovr_valid_held", rd_valid, 1);
        pulse_ready();
        check("ovr_clear_valid", rd_valid, 0);
        check("ovr_clear_overrun", overrun, 0);

        // Load in the same cycle as a consume; stray start mid-frame ignored.
        run_single(0, 16'h2A00, model(16'h2A00), 0);
        sensor_word[1] = 16'h3100;
        @(negedge SYSCLK); start = 1'b1; start_ch = 1'b1;
        @(posedge SYSCLK); #1; start = 1'b0;
        repeat (10) @(posedge SYSCLK);
        @(negedge SYSCLK); start = 1'b1; start_ch = 1'b0;
        @(posedge SYSCLK); #1; start = 1'b0;
        k = 0;
        while (CS != 2'b11 && k < 200) begin
            @(posedge SYSCLK); #1; k++;
        end
        pulse_ready();
        check("coincide_valid", rd_valid, 1);
        check("coincide_overrun", overrun, 0);
        check("coincide_data", rd_data, model(16'h3100));
        check("coincide_ch", rd_ch, 1);
        $display("coincident load ch=%0d rd_data=%h rd_valid=%b overrun=%b", rd_ch, rd_data, rd_valid, overrun);
        cnt = 0;
        repeat (30) begin
            @(posedge SYSCLK); #1;
            if (CS != 2'b11) cnt++;
        end
        check("ignored_start_not_queued", cnt, 0);
        pulse_ready();
        check("coincide_consume", rd_valid, 0);

        // Randomised single-shot frames against the model.
        for (int i = 0; i < 10; i++) begin
            cur = int'($urandom_range(0, 1));
            w = 16'($urandom);
            run_single(cur, w, model(w), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
